// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and default step.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ    = 3'b000;
  localparam logic [2:0] SEL_JUMP   = 3'b001;
  localparam logic [2:0] SEL_BRANCH = 3'b010;
  localparam logic [2:0] SEL_CALL   = 3'b011;
  localparam logic [2:0] SEL_RET    = 3'b100;

  localparam int DEFAULT_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry and pulses ovf.
// Latency 1 (state and ovf update on the edge); never stalls, the caller gates push/pop.
module pc_ras #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;
  logic [CW-1:0]    count;

  assign top_inc  = top + PW'(1);
  assign top_data = mem[top];
  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= push && full;
      if (push) begin
        // When full, top+1 lands on the oldest entry, so the count stays put.
        top <= top_inc;
        if (!full) count <= count + CW'(1);
      end else if (pop && !empty) begin
        top   <= top - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Entry contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[top_inc] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential/jump/branch/call/return modes and an internal RAS.
// Latency 1 (next PC on pc after the edge); en=0 stalls PC and RAS, no other backpressure.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = DEFAULT_STEP,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] jump_addr,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             err,
  output logic             ras_ovf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] top_data;
  logic             push;
  logic             pop;
  logic             err_next;

  assign seq        = pc + STEP_W;
  assign branch_tgt = seq + jump_addr;

  always_comb begin
    pc_next  = pc;
    push     = 1'b0;
    pop      = 1'b0;
    err_next = 1'b0;
    if (en) begin
      case (select)
        SEL_SEQ:    pc_next = seq;
        SEL_JUMP:   pc_next = jump_addr;
        SEL_BRANCH: pc_next = branch_tgt;
        SEL_CALL: begin
          pc_next = jump_addr;
          push    = 1'b1;
        end
        SEL_RET: begin
          // Return on an empty stack falls through to the next instruction.
          if (ras_empty) begin
            pc_next  = seq;
            err_next = 1'b1;
          end else begin
            pc_next = top_data;
            pop     = 1'b1;
          end
        end
        default: err_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      err <= 1'b0;
    end else begin
      pc  <= pc_next;
      err <= err_next;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top_data  (top_data),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (WIDTH=16, STEP=4, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  select;
  logic [15:0] jump_addr;
  logic [15:0] pc;
  logic        ras_empty;
  logic        ras_full;
  logic        err;
  logic        ras_ovf;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [2:0] S_SEQ = 3'b000, S_JMP = 3'b001, S_BR = 3'b010,
                         S_CALL = 3'b011, S_RET = 3'b100;

  pc_unit #(
    .WIDTH     (16),
    .STEP      (4),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .select    (select),
    .jump_addr (jump_addr),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .err       (err),
    .ras_ovf   (ras_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [15:0] a);
    en        = 1'b1;
    select    = s;
    jump_addr = a;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; select = S_SEQ; jump_addr = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_pc", pc, 32'h0);
    check("reset_empty", ras_empty, 1);
    check("reset_full", ras_full, 0);
    check("reset_err", err, 0);
    check("reset_ovf", ras_ovf, 0);

    drive(S_SEQ, 16'h0); check("seq1", pc, 32'h4);
    drive(S_SEQ, 16'h0); check("seq2", pc, 32'h8);
    drive(S_SEQ, 16'h0); check("seq3", pc, 32'hC);
    check("seq_empty", ras_empty, 1);
    drive(S_SEQ, 16'h0); check("seq4", pc, 32'h10);

    drive(S_JMP, 16'h0100); check("jump", pc, 32'h0100);
    drive(S_BR, 16'hFFF0);  check("branch_neg", pc, 32'h00F4);

    drive(S_JMP, 16'hFFFC); check("jump_top", pc, 32'hFFFC);
    drive(S_SEQ, 16'h0);    check("seq_wrap", pc, 32'h0000);
    check("seq_wrap_err", err, 0);
    // Stall with an illegal select: must be ignored entirely.
    en = 1'b0; select = 3'b111; jump_addr = 16'h1234;
    tick(); check("stall1_pc", pc, 32'h0);
    tick(); check("stall2_pc", pc, 32'h0);
    check("stall_err", err, 0);

    drive(S_JMP, 16'h0020);  check("nest_start", pc, 32'h0020);
    drive(S_CALL, 16'h0100); check("nest_call1", pc, 32'h0100);
    check("nest_not_empty", ras_empty, 0);
    drive(S_CALL, 16'h0200); check("nest_call2", pc, 32'h0200);
    drive(S_RET, 16'h0);     check("nest_ret1", pc, 32'h0104);
    drive(S_RET, 16'h0);     check("nest_ret2", pc, 32'h0024);
    check("nest_empty", ras_empty, 1);
    check("nest_err", err, 0);

    drive(S_JMP, 16'h0000);  check("ovf_start", pc, 32'h0);
    drive(S_CALL, 16'h1000); check("ovf_c1", pc, 32'h1000);
    drive(S_CALL, 16'h1010); check("ovf_c2", pc, 32'h1010);
    drive(S_CALL, 16'h1020); check("ovf_c3", pc, 32'h1020);
    check("ovf_not_full", ras_full, 0);
    drive(S_CALL, 16'h1030); check("ovf_c4", pc, 32'h1030);
    check("ovf_full4", ras_full, 1);
    check("ovf_none4", ras_ovf, 0);
    drive(S_CALL, 16'h1040); check("ovf_c5", pc, 32'h1040);
    check("ovf_pulse", ras_ovf, 1);
    check("ovf_full5", ras_full, 1);
    drive(S_RET, 16'h0);     check("ovf_r1", pc, 32'h1034);
    check("ovf_cleared", ras_ovf, 0);
    check("ovf_r1_notfull", ras_full, 0);
    drive(S_RET, 16'h0);     check("ovf_r2", pc, 32'h1024);
    drive(S_RET, 16'h0);     check("ovf_r3", pc, 32'h1014);
    drive(S_RET, 16'h0);     check("ovf_r4", pc, 32'h1004);
    check("ovf_r4_empty", ras_empty, 1);
    check("ovf_r4_err", err, 0);
    drive(S_RET, 16'h0);     check("ret_empty_pc", pc, 32'h1008);
    check("ret_empty_err", err, 1);
    drive(S_SEQ, 16'h0);     check("ret_after_pc", pc, 32'h100C);
    check("ret_after_err", err, 0);

    drive(S_JMP, 16'h0040);  check("ill_start", pc, 32'h0040);
    drive(3'b110, 16'h5555); check("ill_pc", pc, 32'h0040);
    check("ill_err", err, 1);
    drive(S_SEQ, 16'h0);     check("ill_clear_err", err, 0);
    check("ill_after_pc", pc, 32'h0044);
    drive(3'b101, 16'h0);    check("ill101_err", err, 1);
    drive(3'b111, 16'h0);    check("ill111_err", err, 1);
    check("ill111_pc", pc, 32'h0044);

    drive(S_CALL, 16'h0300); check("rst_c1", pc, 32'h0300);
    drive(S_CALL, 16'h0400); check("rst_c2", pc, 32'h0400);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_pc", pc, 32'h0);
    check("midrst_empty", ras_empty, 1);
    check("midrst_err", err, 0);
    drive(S_RET, 16'h0);     check("midrst_ret_pc", pc, 32'h4);
    check("midrst_ret_err", err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC core. It is the successor of the fixed 16-bit PC adjust logic.
- Holds the architectural PC and computes the next PC each enabled cycle. Modes: sequential, absolute jump, PC-relative branch, call and return.
- Call and return use an internal return-address stack (RAS).
- Sits between decode (supplies mode and target) and instruction fetch (consumes pc).

Parameters:
WIDTH, 16, bit width of PC, target and stack entries
STEP, 4, sequential increment added to PC (bytes per instruction)
RAS_DEPTH, 4, number of return-address stack entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  advance enable; 0 = stall (hold PC and RAS)
select  input  3  next-PC mode (encoding below)
jump_addr  input  WIDTH  absolute target or signed relative offset, per mode
pc  output  WIDTH  current PC (registered)
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
err  output  1  one-cycle pulse: illegal select or return on empty RAS
ras_ovf  output  1  one-cycle pulse: call issued while RAS full

Behaviour:
- Reset (rst=1 at posedge, overrides everything):
  - pc=RESET_PC, RAS count=0, ras_empty=1, ras_full=0, err=0, ras_ovf=0.
  - RAS entry contents are don't-care.
- Define seq = pc+STEP. All arithmetic is modulo 2^WIDTH and wraps silently. jump_addr is two's-complement in relative mode.
- select encoding, evaluated only when en=1. Result appears on pc the cycle after the edge (latency 1):
  - 000 SEQ: pc<=seq.
  - 001 JUMP: pc<=jump_addr.
  - 010 BRANCH: pc<=seq+jump_addr.
  - 011 CALL: pc<=jump_addr; push seq onto RAS.
  - 100 RET: pc<=top of RAS; pop.
  - 101-111 illegal: pc<=pc (hold), err=1 for one cycle.
- en=0: pc, RAS and count hold; err and ras_ovf are 0 that cycle; select and jump_addr are ignored.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH):
  - CALL with count<RAS_DEPTH: write seq at top+1, top++, count++.
  - CALL with count==RAS_DEPTH: overwrite the oldest entry (top+1 wraps onto it), top++, count stays, ras_ovf=1 for one cycle. The jump still happens.
  - RET with count>0: pc<=entry[top], top--, count--.
  - RET with count==0: pc<=seq (fall-through), RAS unchanged, err=1 for one cycle.
- Pointer wrap: top indices wrap modulo RAS_DEPTH.
- ras_empty and ras_full are decoded from the registered count, so they reflect state after the last edge.
- err and ras_ovf are registered pulses, asserted in the cycle after the offending edge and cleared the following cycle unless re-triggered.
- Reset asserted mid-sequence (e.g. during a call chain) discards all RAS contents.
- No $display error reporting. Errors are signalled only via err and ras_ovf.

Decomposition:
- Shared package pc_pkg:
  - Select encoding constants SEL_SEQ, SEL_JUMP, SEL_BRANCH, SEL_CALL, SEL_RET.
  - Default STEP.
- One natural sub-module: pc_ras.
  - Parameters WIDTH and RAS_DEPTH.
  - Ports: clk, rst, push, pop, push_data, top_data, empty, full, ovf.
  - Owns the pointer/count logic.
- The next-PC mux and the two adders stay in pc_unit.

Test Plan:
- Reset then 3 cycles of SEQ (WIDTH=16, STEP=4, RESET_PC=0) -> pc=0,4,8,12; ras_empty=1.
- pc=0x0010: JUMP 0x0100 -> pc=0x0100. Then BRANCH 0xFFF0 (-16) -> pc=0x0100+4-16=0x00F4.
- pc=0xFFFC, SEQ -> pc=0x0000 (wrap, no err). Stall with en=0 for 2 cycles -> pc stays 0x0000.
- Nested calls from pc=0x0020 to 0x0100, then from 0x0100 to 0x0200, then RET, RET:
  - pc after the two calls: 0x0100, then 0x0200.
  - pc after the two returns: 0x0104, then 0x0024.
  - ras_empty=1 at end.
- Call from pc=0x0000 to target 0x1000, then four calls, each to pc+0x10 (RAS_DEPTH=4):
  - Pushed returns: 0x0004, 0x1004, 0x1014, 0x1024, 0x1034.
  - 5th call pulses ras_ovf=1, ras_full stays 1.
  - Next 4 RETs -> pc=0x1034, 0x1024, 0x1014, 0x1004.
  - 5th RET -> err=1, pc=0x1004+4=0x1008.
- Illegal select 110 at pc=0x0040 -> pc holds 0x0040, err=1 for exactly one cycle. rst mid-call-chain -> pc=RESET_PC, ras_empty=1.
